// File: rtl/fix_arith_pkg.sv
// Shared definitions for the fixed-point arithmetic layer: divider state
// encoding and saturated quotient patterns as functions of operand width.
package fix_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Widest operand the saturation helpers are expected to describe.
  localparam int unsigned FIX_MAX_WIDTH = 64;

  // Largest positive two's-complement value of width w: 0111...1
  function automatic logic [FIX_MAX_WIDTH-1:0] sat_max_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w: 1000...0
  function automatic logic [FIX_MAX_WIDTH-1:0] sat_most_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fix_divstep.sv
// One restoring division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder and trial-subtract the divisor magnitude.
module fix_divstep
  import fix_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvsr_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // The partial remainder is always below the divisor magnitude (<= 2^(W-1)),
  // so the shifted value fits in W bits and the extra top bit cleanly
  // signals a borrow from the trial subtraction.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, dvsr_mag};
    borrow  = diff[WIDTH];
    quo_bit = ~borrow;
    rem_out = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/fix_signdiv.sv
// Iterative signed fixed-point divider, round-toward-zero quotient and
// remainder, one restoring step per cycle on operand magnitudes.
// Optional: FIX_SIGNDIV_REM_EN enables the remainder register and its sign
// correction; otherwise the remainder port is tied to zero.
module fix_signdiv
  import fix_arith_pkg::*;
#(
  parameter  int unsigned INPUT_WIDTH = 16,
  localparam int unsigned CNT_WIDTH   = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] dividend,
  input  logic [INPUT_WIDTH-1:0] divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] quotient,
  output logic [INPUT_WIDTH-1:0] remainder,
  output logic                   div_by_zero,
  output logic                   overflow
);

  localparam logic [INPUT_WIDTH-1:0] QUO_MAX_POS  = INPUT_WIDTH'(sat_max_pos(INPUT_WIDTH));
  localparam logic [INPUT_WIDTH-1:0] QUO_MOST_NEG = INPUT_WIDTH'(sat_most_neg(INPUT_WIDTH));
  localparam logic [CNT_WIDTH-1:0]   CNT_START    = CNT_WIDTH'(INPUT_WIDTH);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE      = CNT_WIDTH'(1);

  // Magnitude in W unsigned bits; the most negative value maps to 2^(W-1).
  function automatic logic [INPUT_WIDTH-1:0] mag(input logic [INPUT_WIDTH-1:0] x);
    return x[INPUT_WIDTH-1] ? -x : x;
  endfunction

  div_state_t             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0] prem_q, prem_d;
  logic [INPUT_WIDTH-1:0] dvd_q, dvd_d;
  logic [INPUT_WIDTH-1:0] dvsr_q, dvsr_d;
  logic                   neg_quo_q, neg_quo_d;
  logic [INPUT_WIDTH-1:0] quo_q, quo_d;
  logic                   dbz_q, dbz_d;
  logic                   ovf_q, ovf_d;
`ifdef FIX_SIGNDIV_REM_EN
  logic                   neg_rem_q, neg_rem_d;
  logic [INPUT_WIDTH-1:0] rem_q, rem_d;
`endif

  logic [INPUT_WIDTH-1:0] step_rem;
  logic                   step_qbit;
  logic [INPUT_WIDTH-1:0] quo_mag_next;

  fix_divstep #(
    .WIDTH(INPUT_WIDTH)
  ) u_divstep (
    .rem_in  (prem_q),
    .bit_in  (dvd_q[INPUT_WIDTH-1]),
    .dvsr_mag(dvsr_q),
    .rem_out (step_rem),
    .quo_bit (step_qbit)
  );

  // The dividend magnitude register doubles as the quotient accumulator:
  // dividend bits shift out of the top while quotient bits shift in below.
  assign quo_mag_next = {dvd_q[INPUT_WIDTH-2:0], step_qbit};

  // Next-state, operand capture, iteration and result sign correction.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    dvd_d     = dvd_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    quo_d     = quo_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
`ifdef FIX_SIGNDIV_REM_EN
    neg_rem_d = neg_rem_q;
    rem_d     = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d     = mag(dividend);
          dvsr_d    = mag(divisor);
          neg_quo_d = dividend[INPUT_WIDTH-1] ^ divisor[INPUT_WIDTH-1];
          prem_d    = '0;
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
`ifdef FIX_SIGNDIV_REM_EN
          neg_rem_d = dividend[INPUT_WIDTH-1];
`endif
          if (divisor == '0) begin
            quo_d   = dividend[INPUT_WIDTH-1] ? QUO_MOST_NEG : QUO_MAX_POS;
            dbz_d   = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
`ifdef FIX_SIGNDIV_REM_EN
            rem_d   = dividend;
`endif
          end else if (dividend == QUO_MOST_NEG && divisor == '1) begin
            quo_d   = QUO_MAX_POS;
            ovf_d   = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
`ifdef FIX_SIGNDIV_REM_EN
            rem_d   = '0;
`endif
          end else begin
            cnt_d   = CNT_START;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prem_d = step_rem;
        dvd_d  = quo_mag_next;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          quo_d   = neg_quo_q ? -quo_mag_next : quo_mag_next;
          state_d = DONE;
`ifdef FIX_SIGNDIV_REM_EN
          rem_d   = neg_rem_q ? -step_rem : step_rem;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prem_q    <= '0;
      dvd_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      quo_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      dvd_q     <= dvd_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      quo_q     <= quo_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef FIX_SIGNDIV_REM_EN
  // Remainder result and dividend-sign registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
    end else begin
      neg_rem_q <= neg_rem_d;
      rem_q     <= rem_d;
    end
  end

  assign remainder = rem_q;
`else
  assign remainder = '0;
`endif

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fix_signdiv.sv
// Directed and random checks of fix_signdiv against a behavioural model of
// truncating signed division, with a scoreboard queue of expected results.
module tb_fix_signdiv;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  fix_signdiv #(
    .INPUT_WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa;
    int sb_i;
    sa       = int'($signed(a));
    sb_i     = int'($signed(b));
    e.a      = a;
    e.b      = b;
    e.dbz    = 1'b0;
    e.ovf    = 1'b0;
    e.lat    = W + 1;
    if (b == 16'h0000) begin
      e.q   = a[W-1] ? 16'h8000 : 16'h7FFF;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else if (a == 16'h8000 && b == 16'hFFFF) begin
      e.q   = 16'h7FFF;
      e.r   = 16'h0000;
      e.ovf = 1'b1;
      e.lat = 1;
    end else begin
      e.q = 16'(sa / sb_i);
      e.r = 16'(sa % sb_i);
    end
`ifndef FIX_SIGNDIV_REM_EN
    e.r = 16'h0000;
`endif
    return e;
  endfunction

  // Drive one operation, optionally poke in_valid during CALC and stall the
  // result for 'stall' cycles, then compare against the scoreboard head.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    exp_t e;
    int   lat;
    int   sa, sb_i, sq, sr;
    sb.push_back(model(a, b));
    @(negedge clk);
    chk("in_ready_before", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (stall > 0) begin
        in_valid = ~in_valid;
        dividend = 16'd9;
        divisor  = 16'd3;
      end
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 16'd5;
      @(negedge clk);
      chk("stall_quotient", quotient, e.q);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", div_by_zero, e.dbz);
    chk("overflow", overflow, e.ovf);
`ifdef FIX_SIGNDIV_REM_EN
    if (!e.dbz && !e.ovf) begin
      sa   = int'($signed(a));
      sb_i = int'($signed(b));
      sq   = int'($signed(quotient));
      sr   = int'($signed(remainder));
      chk("invariant_eq", (sa == sq * sb_i + sr), 1);
      chk("invariant_rem", ((sr < 0 ? -sr : sr) < (sb_i < 0 ? -sb_i : sb_i)), 1);
    end
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    run_op(16'd100, 16'd7, 0);
    run_op(-16'sd100, 16'd7, 0);
    run_op(16'd100, -16'sd7, 0);
    run_op(-16'sd100, -16'sd7, 0);
    run_op(16'd1234, 16'd0, 0);
    run_op(-16'sd5, 16'd0, 0);
    run_op(16'h8000, 16'hFFFF, 0);
    run_op(16'h8000, 16'd1, 0);
    run_op(16'h7FFF, 16'h8000, 0);
    run_op(16'd7, 16'd100, 0);
    run_op(16'd1000, -16'sd3, 20);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? (16'($urandom_range(0, 20)) - 16'd10) : 16'($urandom);
      run_op(ra, rb, 0);
    end

    // Leave a nonzero result in the output registers, then abort mid-CALC.
    run_op(-16'sd5, 16'd0, 0);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'd30000;
    divisor  = 16'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    chk("abort_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'd100, 16'd7, 0);
    run_op(-16'sd30000, 16'd7, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
